mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares one single-ported, variable-latency memory port between the pipelined core's instruction-fetch requester and its memory-stage data requester. Sits between the core (fetch PC / instruction, data address / write data / wmask / `mem_valid`) and the unified memory or peripheral bus. The block sequences one outstanding transaction at a time and gives data priority over fetch. It returns registered read data with one-cycle done strobes that the core uses as its fetch-valid and `mem_valid` stall inputs.

## Interface
Parameters:
- `ADR_W`, 32, address width.
- `MAX_DATA_BURST`, 4, consecutive data grants allowed while fetch waits (used only with fairness compiled in); legal range 1..15.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `if_req`  in  1  fetch request; held until `if_done` or `if_kill`.
- `if_adr`  in  ADR_W  fetch address (PC); stable while `if_req`.
- `if_kill`  in  1  abandons any pending or in-flight fetch (branch redirect).
- `if_done`  out  1  one-cycle strobe; `if_rdata` is valid.
- `if_rdata`  out  32  fetched instruction, held until the next `if_done`.
- `d_req`  in  1  data request; held until `d_done`.
- `d_we`  in  1  1 = write, 0 = read.
- `d_adr`  in  ADR_W  data address.
- `d_wdata`  in  32  write data.
- `d_wmask`  in  4  byte write mask.
- `d_done`  out  1  one-cycle strobe; the write is accepted or `d_rdata` is valid.
- `d_rdata`  out  32  read data, held until the next data read completes.
- `mem_req`  out  1  registered request to memory.
- `mem_we`, `mem_adr`, `mem_wdata`, `mem_wmask`  out  1/ADR_W/32/4  registered command fields; stable while `mem_req`.
- `mem_ready`  in  1  memory accepts the command in any cycle where `mem_req && mem_ready`.
- `mem_rvalid`  in  1  read response strobe.
- `mem_rdata`  in  32  read response data.

## Operation
- States: `IDLE`, `IF_CMD`, `IF_RSP`, `D_CMD`, `D_RSP`. One transaction is outstanding at most.
- **IDLE:**
  - If `d_req`, latch the data command and go to `D_CMD`.
  - Else if `if_req && !if_kill`, latch `if_adr` and go to `IF_CMD`.
  - `mem_rvalid` is ignored.
- **X_CMD:**
  - `mem_req`=1 with the latched fields.
  - On `mem_ready`: a write goes to `IDLE` and `d_done` pulses next cycle; a read goes to X_RSP and `mem_req` drops the same edge.
- **X_RSP:**
  - On `mem_rvalid`, capture `mem_rdata` into the if/d read register, pulse done next cycle, and go to `IDLE`.
- **`if_kill`:**
  - In `IF_CMD` before acceptance, drop `mem_req` and go to `IDLE`.
  - In `IF_RSP`, set a discard flag; the response is consumed without an `if_done` or `if_rdata` update.
  - Data transactions are never killed.
- `d_req` and `if_req` present in the same IDLE cycle: data wins, and fetch waits.
- Requester address or field changes while in X_CMD/X_RSP have no effect (latched copy used).
- A requester that deasserts before done is a protocol error; the transaction still completes and the strobe still fires.

## Timing
- Reset values: `mem_req`, `mem_we`, `if_done`, `d_done`=0; `mem_adr`, `mem_wdata`, `mem_wmask`, `if_rdata`, `d_rdata`=0; state `IDLE`; discard flag 0; burst counter 0.
- Read with zero-wait memory:
  - Request seen in IDLE at cycle N.
  - `mem_req` high at N+1 and accepted at N+1.
  - `mem_rvalid` at N+2.
  - done and rdata at N+3.
  - Minimum read latency is 3 cycles.
- Write: request at N, accepted at N+1, `d_done` at N+2.
- The next transaction can start in IDLE on the cycle the done strobe is high (back-to-back throughput: 1 read per 3 cycles).
- `mem_ready` stalls extend X_CMD indefinitely, and `mem_rvalid` delay extends X_RSP indefinitely; there is no timeout.
- Reset assertion mid-transaction returns to IDLE immediately. A late `mem_rvalid` after reset is ignored.

## Configuration
- `MEM_ARB_FAIRNESS_EN`:
  - When defined:
    - A 4-bit counter increments on each data grant taken while `if_req` is pending.
    - When it reaches `MAX_DATA_BURST`, the next IDLE decision grants fetch even if `d_req` is high.
    - The counter clears on any fetch grant or whenever `if_req` is low.
  - When undefined: strict data priority; the counter is absent.

## Test plan
- Reset then a single fetch, `if_adr`=0x00000010, memory returns 0x00500093 after 2 cycles → `if_done` one cycle with `if_rdata`=0x00500093, and `mem_req` high exactly one cycle.
- `d_req` and `if_req` in the same cycle, data read 0x80 → data granted first; fetch `mem_req` starts the cycle after `d_done`.
- Data write, `d_wmask`=0x3, `mem_ready` low 3 cycles → `mem_req` held 4 cycles with stable fields; `d_done` 1 cycle after acceptance, and no `mem_rvalid` is needed.
- `if_kill` during IF_RSP, memory returns 0xDEADBEEF → no `if_done`; `if_rdata` keeps its previous value; the state returns to IDLE.
- Continuous `d_req` plus `if_req` with `MEM_ARB_FAIRNESS_EN`, `MAX_DATA_BURST`=4 → fetch granted after exactly 4 data grants. Without the macro, fetch is never granted while `d_req` is held.
- Reset asserted during D_RSP, then `mem_rvalid` → outputs at reset values, no `d_done`, state IDLE.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported, variable-latency memory port between the
//   instruction-fetch requester and the data requester. One transaction is
//   outstanding at a time; data has priority over fetch. Done strobes are
//   registered one-cycle pulses; read data is held until the next completion.
//
//   Optional feature macro: MEM_ARB_FAIRNESS_EN
//     defined   : after MAX_DATA_BURST data grants taken while fetch waits,
//                 the next grant goes to fetch.
//     undefined : strict data priority.
//
// Ports
//   clk, rst                 clock, asynchronous active-low reset
//   if_req/if_adr/if_kill    fetch request, PC, redirect kill
//   if_done/if_rdata         fetch completion strobe and instruction
//   d_req/d_we/d_adr/
//   d_wdata/d_wmask          data request and command fields
//   d_done/d_rdata           data completion strobe and read data
//   mem_req/mem_we/mem_adr/
//   mem_wdata/mem_wmask      registered memory command
//   mem_ready                command accepted when mem_req && mem_ready
//   mem_rvalid/mem_rdata     read response
module mem_port_arbiter #(
    parameter int ADR_W          = 32,
    parameter int MAX_DATA_BURST = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_req,
    input  logic [ADR_W-1:0] if_adr,
    input  logic             if_kill,
    output logic             if_done,
    output logic [31:0]      if_rdata,
    input  logic             d_req,
    input  logic             d_we,
    input  logic [ADR_W-1:0] d_adr,
    input  logic [31:0]      d_wdata,
    input  logic [3:0]       d_wmask,
    output logic             d_done,
    output logic [31:0]      d_rdata,
    output logic             mem_req,
    output logic             mem_we,
    output logic [ADR_W-1:0] mem_adr,
    output logic [31:0]      mem_wdata,
    output logic [3:0]       mem_wmask,
    input  logic             mem_ready,
    input  logic             mem_rvalid,
    input  logic [31:0]      mem_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        IF_CMD,
        IF_RSP,
        D_CMD,
        D_RSP
    } state_e;

    if ((MAX_DATA_BURST < 1) || (MAX_DATA_BURST > 15)) begin : g_burst_range
        $error("mem_port_arbiter: MAX_DATA_BURST must be in 1..15");
    end

    state_e           state_q;
    logic             discard_q;
    logic             if_done_q;
    logic [31:0]      if_rdata_q;
    logic             d_done_q;
    logic [31:0]      d_rdata_q;
    logic             mem_req_q;
    logic             mem_we_q;
    logic [ADR_W-1:0] mem_adr_q;
    logic [31:0]      mem_wdata_q;
    logic [3:0]       mem_wmask_q;

    logic             take_data;
    logic             take_fetch;

`ifdef MEM_ARB_FAIRNESS_EN
    localparam logic [3:0] BURST_LIM = 4'(MAX_DATA_BURST);
    logic [3:0] burst_q;
`endif

    // IDLE grant decision; only acted on while state_q == IDLE.
    always_comb begin
        take_data  = d_req;
        take_fetch = !d_req && if_req && !if_kill;
`ifdef MEM_ARB_FAIRNESS_EN
        // Fetch has waited through a full data burst: it goes first.
        if ((burst_q >= BURST_LIM) && if_req && !if_kill) begin
            take_data  = 1'b0;
            take_fetch = 1'b1;
        end
`endif
    end

`ifdef MEM_ARB_FAIRNESS_EN
    // Counts data grants taken while fetch is pending; saturates at 15.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            burst_q <= '0;
        end else if (!if_req) begin
            burst_q <= '0;
        end else if (state_q == IDLE) begin
            if (take_fetch) begin
                burst_q <= '0;
            end else if (take_data && (burst_q != 4'hF)) begin
                burst_q <= burst_q + 4'd1;
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            discard_q   <= 1'b0;
            if_done_q   <= 1'b0;
            if_rdata_q  <= '0;
            d_done_q    <= 1'b0;
            d_rdata_q   <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_adr_q   <= '0;
            mem_wdata_q <= '0;
            mem_wmask_q <= '0;
        end else begin
            if_done_q <= 1'b0;
            d_done_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (take_data) begin
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= d_we;
                        mem_adr_q   <= d_adr;
                        mem_wdata_q <= d_wdata;
                        mem_wmask_q <= d_wmask;
                        state_q     <= D_CMD;
                    end else if (take_fetch) begin
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b0;
                        mem_adr_q   <= if_adr;
                        mem_wmask_q <= '0;
                        state_q     <= IF_CMD;
                    end
                end
                IF_CMD: begin
                    // A kill coinciding with acceptance cannot retract the
                    // command, so the response is waited for and dropped.
                    if (mem_ready) begin
                        mem_req_q <= 1'b0;
                        discard_q <= if_kill;
                        state_q   <= IF_RSP;
                    end else if (if_kill) begin
                        mem_req_q <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                IF_RSP: begin
                    if (mem_rvalid) begin
                        if (!(discard_q || if_kill)) begin
                            if_rdata_q <= mem_rdata;
                            if_done_q  <= 1'b1;
                        end
                        discard_q <= 1'b0;
                        state_q   <= IDLE;
                    end else if (if_kill) begin
                        discard_q <= 1'b1;
                    end
                end
                D_CMD: begin
                    if (mem_ready) begin
                        mem_req_q <= 1'b0;
                        if (mem_we_q) begin
                            d_done_q <= 1'b1;
                            state_q  <= IDLE;
                        end else begin
                            state_q <= D_RSP;
                        end
                    end
                end
                D_RSP: begin
                    if (mem_rvalid) begin
                        d_rdata_q <= mem_rdata;
                        d_done_q  <= 1'b1;
                        state_q   <= IDLE;
                    end
                end
                default: begin
                    mem_req_q <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign if_done   = if_done_q;
    assign if_rdata  = if_rdata_q;
    assign d_done    = d_done_q;
    assign d_rdata   = d_rdata_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_adr   = mem_adr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wmask = mem_wmask_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: a memory model with programmable
// ready stalls and response gap, directed requester stimulus, and a
// scoreboard of expected completions checked by a separate monitor.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_kill, if_done;
    logic [31:0] if_adr, if_rdata;
    logic        d_req, d_we, d_done;
    logic [31:0] d_adr, d_wdata, d_rdata;
    logic [3:0]  d_wmask;
    logic        mem_req, mem_we, mem_ready, mem_rvalid;
    logic [31:0] mem_adr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wmask;

    mem_port_arbiter #(.ADR_W(32), .MAX_DATA_BURST(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_adr(if_adr), .if_kill(if_kill),
        .if_done(if_done), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_adr(d_adr), .d_wdata(d_wdata),
        .d_wmask(d_wmask), .d_done(d_done), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_adr(mem_adr),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    // ---------------- scoreboard ----------------
    typedef struct {
        bit          is_d;
        bit          is_wr;
        logic [31:0] data;
    } exp_t;
    exp_t sb_q[$];

    function automatic void push_exp(input bit is_d, input bit is_wr, input logic [31:0] data);
        exp_t e;
        e.is_d = is_d; e.is_wr = is_wr; e.data = data;
        sb_q.push_back(e);
    endfunction

    // ---------------- memory model ----------------
    logic [31:0] mem_img [logic [31:0]];
    int stall_cfg = 0, stall_left = 0, gap = 0, rsp_wait = 0;
    bit rsp_armed = 0, acc_we = 0;
    logic [31:0] acc_adr = '0, rsp_data = '0;

    function automatic logic [31:0] lookup(input logic [31:0] a);
        if (mem_img.exists(a)) return mem_img[a];
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic set_mem(input int stall, input int g);
        stall_cfg = stall; stall_left = stall; gap = g;
    endtask

    initial begin
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            if (mem_ready) begin
                if (!acc_we) begin
                    rsp_armed = 1; rsp_wait = gap; rsp_data = lookup(acc_adr);
                end
                stall_left = stall_cfg;
            end
            mem_ready = 1'b0; mem_rvalid = 1'b0;
            if (rsp_armed) begin
                if (rsp_wait == 0) begin
                    mem_rvalid = 1'b1; mem_rdata = rsp_data; rsp_armed = 0;
                end else rsp_wait--;
            end
            if (mem_req) begin
                if (stall_left == 0) begin
                    mem_ready = 1'b1; acc_we = mem_we; acc_adr = mem_adr;
                end else stall_left--;
            end
        end
    end

    // ---------------- monitor ----------------
    typedef struct {
        int          cyc;
        logic        we;
        logic [31:0] adr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
    } rise_t;
    rise_t rise_q[$];
    int mreq_cycles = 0, if_done_cnt = 0, d_done_cnt = 0;
    bit prev_req = 0;
    logic [31:0] hold_adr, hold_wdata;
    logic [4:0]  hold_ctl;

    function automatic void sb_pop(input bit is_d, input logic [31:0] data);
        exp_t e;
        if (sb_q.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL unexpected_done: got %s done, required none", is_d ? "d" : "if");
        end else begin
            e = sb_q.pop_front();
            chk("done_kind_is_d", 32'(is_d), 32'(e.is_d));
            if (!e.is_wr) chk(is_d ? "d_rdata" : "if_rdata", data, e.data);
        end
    endfunction

    initial begin
        rise_t r;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev_req = 0;
            end else begin
                if (mem_req) begin
                    mreq_cycles++;
                    if (!prev_req) begin
                        r.cyc = cyc; r.we = mem_we; r.adr = mem_adr;
                        r.wdata = mem_wdata; r.wmask = mem_wmask;
                        rise_q.push_back(r);
                    end else begin
                        chk("cmd_adr_stable", mem_adr, hold_adr);
                        chk("cmd_wdata_stable", mem_wdata, hold_wdata);
                        chk("cmd_we_wmask_stable", 32'({mem_we, mem_wmask}), 32'(hold_ctl));
                    end
                end
                hold_adr = mem_adr; hold_wdata = mem_wdata; hold_ctl = {mem_we, mem_wmask};
                prev_req = mem_req;
                if (if_done) begin if_done_cnt++; sb_pop(1'b0, if_rdata); end
                if (d_done)  begin d_done_cnt++;  sb_pop(1'b1, d_rdata);  end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_done(input bit is_d, input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (is_d ? d_done : if_done) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) begin
            vectors++; miscompares++;
            $display("FAIL %s_done_timeout: got no strobe, required one within %0d cycles",
                     is_d ? "d" : "if", budget);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    function automatic int data_before_fetch();
        int n = 0;
        foreach (rise_q[i]) begin
            if (!rise_q[i].we && (rise_q[i].adr == 32'h200)) return n;
            n++;
        end
        return -1;
    endfunction

    initial begin
        int c0, at, atd, cnt0, nd;
        rst = 1'b0; if_req = 0; if_adr = '0; if_kill = 0;
        d_req = 0; d_we = 0; d_adr = '0; d_wdata = '0; d_wmask = '0;
        idle(2);
        chk("rst_mem_req", 32'(mem_req), 32'h0);
        chk("rst_mem_we", 32'(mem_we), 32'h0);
        chk("rst_if_done", 32'(if_done), 32'h0);
        chk("rst_d_done", 32'(d_done), 32'h0);
        chk("rst_mem_adr", mem_adr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_mem_wmask", 32'(mem_wmask), 32'h0);
        chk("rst_if_rdata", if_rdata, 32'h0);
        chk("rst_d_rdata", d_rdata, 32'h0);
        rst = 1'b1;
        idle(2);

        // single fetch, response two cycles after acceptance
        set_mem(0, 1);
        mem_img[32'h10] = 32'h0050_0093;
        push_exp(1'b0, 1'b0, 32'h0050_0093);
        mreq_cycles = 0; c0 = cyc;
        if_req = 1; if_adr = 32'h10;
        wait_done(1'b0, 20, at);
        if_req = 0;
        chk("fetch_done_cycle", 32'(at), 32'(c0 + 4));
        chk("fetch_mreq_cycles", 32'(mreq_cycles), 32'd1);
        idle(2);

        // simultaneous requests: data first, fetch right after d_done
        set_mem(0, 0);
        mem_img[32'h80] = 32'h1122_3344;
        mem_img[32'h40] = 32'h5566_7788;
        push_exp(1'b1, 1'b0, 32'h1122_3344);
        push_exp(1'b0, 1'b0, 32'h5566_7788);
        rise_q.delete(); c0 = cyc;
        d_req = 1; d_we = 0; d_adr = 32'h80;
        if_req = 1; if_adr = 32'h40;
        wait_done(1'b1, 20, atd);
        d_req = 0;
        chk("prio_d_done_cycle", 32'(atd), 32'(c0 + 3));
        wait_done(1'b0, 20, at);
        if_req = 0;
        chk("prio_if_done_cycle", 32'(at), 32'(c0 + 6));
        chk("prio_rise_count", 32'(rise_q.size()), 32'd2);
        if (rise_q.size() == 2) begin
            chk("prio_first_adr", rise_q[0].adr, 32'h80);
            chk("prio_first_cyc", 32'(rise_q[0].cyc), 32'(c0 + 1));
            chk("prio_fetch_adr", rise_q[1].adr, 32'h40);
            chk("prio_fetch_cyc", 32'(rise_q[1].cyc), 32'(atd + 1));
        end
        idle(2);

        // write with three ready stalls
        set_mem(3, 0);
        push_exp(1'b1, 1'b1, 32'h0);
        rise_q.delete(); mreq_cycles = 0; c0 = cyc;
        d_req = 1; d_we = 1; d_adr = 32'h100; d_wdata = 32'hCAFE_F00D; d_wmask = 4'h3;
        wait_done(1'b1, 20, at);
        d_req = 0; d_we = 0;
        chk("wr_done_cycle", 32'(at), 32'(c0 + 5));
        chk("wr_mreq_cycles", 32'(mreq_cycles), 32'd4);
        if (rise_q.size() > 0) begin
            chk("wr_we", 32'(rise_q[0].we), 32'h1);
            chk("wr_adr", rise_q[0].adr, 32'h100);
            chk("wr_wdata", rise_q[0].wdata, 32'hCAFE_F00D);
            chk("wr_wmask", 32'(rise_q[0].wmask), 32'h3);
        end
        idle(2);

        // kill while waiting for the fetch response
        set_mem(0, 2);
        mem_img[32'h20] = 32'hDEAD_BEEF;
        cnt0 = if_done_cnt;
        if_req = 1; if_adr = 32'h20;
        idle(2);
        if_kill = 1; if_req = 0;
        idle(1);
        if_kill = 0;
        idle(6);
        chk("kill_no_if_done", 32'(if_done_cnt), 32'(cnt0));
        chk("kill_if_rdata_held", if_rdata, 32'h5566_7788);
        set_mem(0, 0);
        mem_img[32'h24] = 32'h00A0_0113;
        push_exp(1'b0, 1'b0, 32'h00A0_0113);
        c0 = cyc;
        if_req = 1; if_adr = 32'h24;
        wait_done(1'b0, 20, at);
        if_req = 0;
        chk("post_kill_fetch_cycle", 32'(at), 32'(c0 + 3));
        idle(2);

        // continuous data writes with a waiting fetch
        set_mem(0, 0);
        mem_img[32'h200] = 32'h0000_0013;
        rise_q.delete();
        d_we = 1; d_adr = 32'h300; d_wdata = 32'h1; d_wmask = 4'hF;
`ifdef MEM_ARB_FAIRNESS_EN
        for (int i = 0; i < 4; i++) push_exp(1'b1, 1'b1, 32'h0);
        push_exp(1'b0, 1'b0, 32'h0000_0013);
        d_req = 1; if_req = 1; if_adr = 32'h200;
        wait_done(1'b0, 60, at);
        d_req = 0; if_req = 0;
        chk("fair_data_grants_before_fetch", 32'(data_before_fetch()), 32'd4);
`else
        for (int i = 0; i < 6; i++) push_exp(1'b1, 1'b1, 32'h0);
        push_exp(1'b0, 1'b0, 32'h0000_0013);
        d_req = 1; if_req = 1; if_adr = 32'h200;
        for (int i = 0; i < 6; i++) wait_done(1'b1, 20, at);
        d_req = 0;
        wait_done(1'b0, 20, at);
        if_req = 0;
        chk("strict_data_grants_before_fetch", 32'(data_before_fetch()), 32'd6);
`endif
        d_we = 0;
        idle(2);

        // reset during D_RSP, then a late response
        set_mem(0, 5);
        mem_img[32'h90] = 32'h9999_9999;
        cnt0 = d_done_cnt;
        d_req = 1; d_we = 0; d_adr = 32'h90;
        idle(2);
        rst = 1'b0; d_req = 0;
        #1;
        chk("midrst_mem_req", 32'(mem_req), 32'h0);
        chk("midrst_d_rdata", d_rdata, 32'h0);
        chk("midrst_mem_adr", mem_adr, 32'h0);
        idle(2);
        rst = 1'b1;
        idle(6);
        chk("late_rvalid_no_d_done", 32'(d_done_cnt), 32'(cnt0));
        chk("late_rvalid_d_rdata", d_rdata, 32'h0);
        chk("late_rvalid_mem_req", 32'(mem_req), 32'h0);
        set_mem(0, 0);
        push_exp(1'b1, 1'b1, 32'h0);
        c0 = cyc;
        d_req = 1; d_we = 1; d_adr = 32'h104; d_wdata = 32'h5; d_wmask = 4'h1;
        wait_done(1'b1, 20, at);
        d_req = 0; d_we = 0;
        chk("post_rst_write_cycle", 32'(at), 32'(c0 + 2));
        idle(4);

        chk("scoreboard_empty", 32'(sb_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
